out_port_fifo: RTL and testbench
================================

// Module: out_port_fifo
// PURPOSE
//  Output-port queue between the CPU datapath and the tri-state-free output buffer stage.
//  Captures 10-bit words written by OUT instructions, holds them in a small FIFO and
//  presents the oldest word with an enable (OE) to the output buffer until an external
//  consumer acknowledges it. Decouples CPU write timing from the consumer's timing.
// PARAMETERS
//  WIDTH   10  data word width (matches CPU bus)
//  DEPTH   4   FIFO entries; power of 2, >= 2
//  ADDR_W  2   pointer width = $clog2(DEPTH); count width is ADDR_W+1
// PORTS
//  Clock     in   1        system clock, all state on rising edge
//  Resetn    in   1        asynchronous, active-low reset
//  wr_en     in   1        CPU push request (one word per cycle)
//  wr_data   in   WIDTH    word to push
//  flush     in   1        synchronous queue clear
//  ack       in   1        consumer accepted the presented word
//  ovf_clr   in   1        clear sticky overflow flag
//  OE        out  1        word valid; drives output buffer enable
//  data      out  WIDTH    oldest queued word; all zeros when OE=0
//  full      out  1        count == DEPTH
//  empty     out  1        count == 0
//  count     out  ADDR_W+1 number of queued words, 0..DEPTH
//  ovf       out  1        sticky: a push was dropped
// BEHAVIOUR
//  Reset (Resetn=0, async): wr_ptr=rd_ptr=0, count=0, ovf=0 -> OE=0, data=0, empty=1, full=0.
//  OE = !empty; data = OE ? mem[rd_ptr] : 0. Both derived from registered state only (no
//   combinational path from wr_en/ack to OE/data).
//  pop  = ack & OE.  ack while OE=0 is ignored.
//  push = wr_en & (!full | pop): write wr_data at mem[wr_ptr], wr_ptr += 1.
//  pop: rd_ptr += 1. Pointers wrap modulo DEPTH (DEPTH-1 -> 0).
//  count: +1 on push only, -1 on pop only, unchanged on push&pop or neither.
//  Latency: word pushed in cycle N presented (OE=1) from cycle N+1; a word acked in cycle
//   N is replaced by the next word (or OE=0) in cycle N+1. Throughput 1 word/cycle.
//  Full + wr_en + pop same cycle: push accepted, count stays DEPTH, no overflow.
//  Full + wr_en, no pop: word dropped, state unchanged, ovf<=1 next cycle.
//  Empty + wr_en + ack: ack ignored, push accepted, count 0->1.
//  ovf: set on dropped push, cleared by ovf_clr; set and clear same cycle -> set wins.
//  flush (sync): pointers and count <= 0 next cycle; overrides push and pop that cycle;
//   ovf unaffected. Memory contents need not be cleared (data gated to 0 when empty).
//  Reset mid-operation: all queued words discarded, outputs to reset values immediately.
//  Storage: DEPTH x WIDTH register array, no reset required on the array itself.
// TESTING
//  T1 reset: Resetn=0 mid-traffic -> OE=0, data=0x000, count=0, empty=1, ovf=0 at once.
//  T2 push 0x155 (ack=0) -> next cycle OE=1, data=0x155, count=1; ack=1 -> next OE=0, data=0.
//  T3 push 0x001..0x004 back-to-back -> full=1, count=4; push 0x3FF -> dropped, ovf=1;
//     ack x4 -> data 0x001,0x002,0x003,0x004 in order, then empty=1; ovf_clr -> ovf=0.
//  T4 full, wr_en=1 (0x2AA) with ack=1 -> count stays 4, ovf=0, 0x2AA emerges last.
//  T5 streaming: push and ack every cycle for 10 words (wraps pointers twice) -> in-order
//     output, count toggles 1, no loss; flush with count=3 -> next cycle count=0, OE=0.

Source files
------------

// File: rtl/out_port_fifo_if.sv
// Output-port queue bus: CPU push side, consumer ack side and queue status.
// The master modport belongs to the CPU/consumer side; the FIFO takes slave.
interface out_port_fifo_if #(
  parameter int WIDTH  = 10,
  parameter int ADDR_W = 2
);
  logic              wr_en;
  logic [WIDTH-1:0]  wr_data;
  logic              flush;
  logic              ack;
  logic              ovf_clr;
  logic              OE;
  logic [WIDTH-1:0]  data;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   count;
  logic              ovf;

  modport master (
    output wr_en, wr_data, flush, ack, ovf_clr,
    input  OE, data, full, empty, count, ovf
  );

  modport slave (
    input  wr_en, wr_data, flush, ack, ovf_clr,
    output OE, data, full, empty, count, ovf
  );
endinterface

// File: rtl/out_port_fifo.sv
// Output-port FIFO: queues OUT-instruction words and presents the oldest one
// with OE until the consumer acks it. Sticky overflow flags dropped pushes.
module out_port_fifo #(
  parameter int WIDTH  = 10,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic             Clock,
  input  logic             Resetn,
  out_port_fifo_if.slave   bus
);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   cnt;
  logic              ovf_q;

  logic empty_w;
  logic full_w;
  logic pop;
  logic push;
  logic drop;

  assign empty_w = (cnt == '0);
  assign full_w  = (cnt == (ADDR_W+1)'(DEPTH));

  // A pop in the same cycle frees a slot, so a full queue can still accept.
  assign pop  = bus.ack & ~empty_w;
  assign push = bus.wr_en & (~full_w | pop);
  assign drop = bus.wr_en & full_w & ~pop;

  always_ff @(posedge Clock) begin
    if (push && !bus.flush) begin
      mem[wr_ptr] <= bus.wr_data;
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
      unique case ({push, pop})
        2'b10:   cnt <= cnt + (ADDR_W+1)'(1);
        2'b01:   cnt <= cnt - (ADDR_W+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Set wins over clear; flush leaves the flag alone.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      ovf_q <= 1'b0;
    end else if (drop) begin
      ovf_q <= 1'b1;
    end else if (bus.ovf_clr) begin
      ovf_q <= 1'b0;
    end
  end

  assign bus.OE    = ~empty_w;
  assign bus.data  = empty_w ? '0 : mem[rd_ptr];
  assign bus.full  = full_w;
  assign bus.empty = empty_w;
  assign bus.count = cnt;
  assign bus.ovf   = ovf_q;

endmodule

// File: tb/tb_out_port_fifo.sv
// Bench for out_port_fifo: directed scenarios plus random traffic, checked by
// a queue-based reference model and a negedge monitor.
module tb_out_port_fifo;
  localparam int WIDTH  = 10;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 2;

  logic Clock;
  logic Resetn;

  out_port_fifo_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

  out_port_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .bus    (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: number of queued words, expected ovf, expected words in order.
  int               mcount = 0;
  logic             movf   = 1'b0;
  logic [WIDTH-1:0] sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, advance the model across the edge, move off the edge.
  task automatic step(input logic w, input logic [WIDTH-1:0] d, input logic f,
                      input logic a, input logic c);
    logic p, pu, dr;
    bus.wr_en   = w;
    bus.wr_data = d;
    bus.flush   = f;
    bus.ack     = a;
    bus.ovf_clr = c;
    @(posedge Clock);
    if (Resetn) begin
      p  = a && (mcount > 0);
      pu = w && ((mcount < DEPTH) || p);
      dr = w && (mcount == DEPTH) && !p;
      if (f) begin
        mcount = 0;
        sb.delete();
      end else begin
        if (pu) sb.push_back(d);
        mcount = mcount + int'(pu) - int'(p);
      end
      if (dr) movf = 1'b1;
      else if (c) movf = 1'b0;
    end
    #1;
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    Resetn = 1'b0;
    #1;
    chk("rst_oe",    32'(bus.OE),    32'd0);
    chk("rst_data",  32'(bus.data),  32'd0);
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_empty", 32'(bus.empty), 32'd1);
    chk("rst_full",  32'(bus.full),  32'd0);
    chk("rst_ovf",   32'(bus.ovf),   32'd0);
    mcount = 0;
    movf   = 1'b0;
    sb.delete();
    idle();
    idle();
    Resetn = 1'b1;
  endtask

  // Monitor: compares presented state against the model and retires acked words.
  always @(negedge Clock) begin
    chk("count", 32'(bus.count), 32'(mcount));
    chk("oe",    32'(bus.OE),    32'(mcount > 0));
    chk("empty", 32'(bus.empty), 32'(mcount == 0));
    chk("full",  32'(bus.full),  32'(mcount == DEPTH));
    chk("ovf",   32'(bus.ovf),   32'(movf));
    if (bus.OE) begin
      if (sb.size() == 0) begin
        chk("data_unexpected", 32'(bus.data), 32'hFFFF_FFFF);
      end else begin
        chk("data", 32'(bus.data), 32'(sb[0]));
        if (bus.ack) void'(sb.pop_front());
      end
    end else begin
      chk("data_zero", 32'(bus.data), 32'd0);
    end
  end

  initial begin
    Resetn      = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_data = '0;
    bus.flush   = 1'b0;
    bus.ack     = 1'b0;
    bus.ovf_clr = 1'b0;
    #12;
    do_reset();

    // Single word, then acked away.
    step(1'b1, 10'h155, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    idle();

    // Fill, overflow, drain in order, clear ovf.
    for (int unsigned i = 1; i <= 4; i++) step(1'b1, 10'(i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 10'h3FF, 1'b0, 1'b0, 1'b0);
    for (int unsigned i = 0; i < 4; i++) step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    idle();

    // Full with simultaneous push and pop: no overflow, new word comes out last.
    for (int unsigned i = 0; i < 4; i++) step(1'b1, 10'(10 + i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 10'h2AA, 1'b0, 1'b1, 1'b0);
    for (int unsigned i = 0; i < 4; i++) step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    idle();

    // Streaming through pointer wrap, then flush with three queued.
    for (int unsigned i = 0; i < 10; i++) step(1'b1, 10'(32 + i), 1'b0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    for (int unsigned i = 0; i < 3; i++) step(1'b1, 10'(64 + i), 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    idle();

    // Set and clear of ovf in the same cycle: set wins.
    for (int unsigned i = 0; i < 4; i++) step(1'b1, 10'(80 + i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 10'h111, 1'b0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b1, 1'b0, 1'b1);
    idle();

    // Random traffic with a mid-stream reset.
    for (int unsigned n = 0; n < 3000; n++) begin
      if (n == 1500) do_reset();
      step($urandom_range(0, 3) != 0, 10'($urandom), $urandom_range(0, 31) == 0,
           $urandom_range(0, 2) != 0, $urandom_range(0, 7) == 0);
    end
    idle();
    @(negedge Clock);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
